// File: rtl/risc_run_pkg.sv
// risc_run_pkg: state encoding and parameter defaults shared by the run controller files
package risc_run_pkg;
    localparam int PC_W_DEF     = 16;
    localparam int CNT_W_DEF    = 32;
    localparam int RST_HOLD_DEF = 4;
    localparam int HALT_WIN_DEF = 8;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLD      = 3'd1,
        S_RUN       = 3'd2,
        S_STEP_WAIT = 3'd3,
        S_DONE      = 3'd4
    } run_state_e;
endpackage

// File: rtl/run_halt_det.sv
// run_halt_det: flags a halt when HALT_WIN consecutive enabled cycles see the same pc
module run_halt_det
    import risc_run_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int HALT_WIN = HALT_WIN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            halt
);
    logic [PC_W-1:0] pc_q;
    logic            vld_q;
    logic [7:0]      run_q, run_d;
    assign run_d = (vld_q && pc == pc_q) ? run_q + 8'd1 : 8'd1;
    assign halt  = en && run_d == 8'(HALT_WIN);
    // Track the previous enabled-cycle pc and the length of the current equal-pc run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            vld_q <= 1'b0;
            run_q <= '0;
        end else if (clr) begin
            vld_q <= 1'b0;
            run_q <= '0;
        end else if (en) begin
            pc_q  <= pc;
            vld_q <= 1'b1;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/risc_run_ctrl.sv
// risc_run_ctrl: core reset/enable sequencer with cycle limit and halt detection (single-step with RUN_CTRL_STEP_EN)
module risc_run_ctrl
    import risc_run_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_HOLD = RST_HOLD_DEF,
    parameter int HALT_WIN = HALT_WIN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [PC_W-1:0]  pc,
    input  logic [CNT_W-1:0] max_cycles,
    output logic             core_rst_n,
    output logic             core_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic             timeout,
    output logic             halted
);
    run_state_e       state_q;
    logic [7:0]       hold_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, timeout_q, halted_q;
    logic             en, clr, halt, hit_max, to_wait, resume;
`ifdef RUN_CTRL_STEP_EN
    assign to_wait = step_mode;
    assign resume  = !step_mode || step;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step;
    assign to_wait     = 1'b0;
    assign resume      = 1'b1;
`endif
    assign en      = state_q == S_RUN;
    assign clr     = start && (state_q == S_IDLE || state_q == S_DONE);
    assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign hit_max = (max_cycles != '0) && (cnt_d == max_cycles);
    run_halt_det #(.PC_W(PC_W), .HALT_WIN(HALT_WIN)) u_halt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .en   (en),
        .pc   (pc),
        .halt (halt)
    );
    // Sequence reset hold, run/step and completion, with the cycle counter and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) begin
                    state_q   <= S_HOLD;
                    hold_q    <= '0;
                    cnt_q     <= '0;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
                S_HOLD: begin
                    hold_q <= hold_q + 8'd1;
                    if (hold_q == 8'(RST_HOLD - 1)) state_q <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (hit_max || halt) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= hit_max;
                        halted_q  <= halt;
                    end else if (to_wait) begin
                        state_q <= S_STEP_WAIT;
                    end
                end
                S_STEP_WAIT: if (resume) state_q <= S_RUN;
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign core_rst_n = !(state_q == S_IDLE || state_q == S_HOLD);
    assign core_en    = en;
    assign state      = state_q;
    assign cycle_cnt  = cnt_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign halted     = halted_q;
endmodule

// File: tb/tb_risc_run_ctrl.sv
// tb_risc_run_ctrl: directed and randomized checks of risc_run_ctrl against a behavioural model
module tb_risc_run_ctrl;
    import risc_run_pkg::*;
    localparam int PC_W = 16;
    localparam int CNT_W = 32;
    localparam int RST_HOLD = 4;
    localparam int HALT_WIN = 8;
`ifdef RUN_CTRL_STEP_EN
    localparam int STEP_EN_CNT = 4;
`else
    localparam int STEP_EN_CNT = 36;
`endif
    logic clk = 0, rst_n = 0, start = 0, step_mode = 0, step = 0;
    logic [PC_W-1:0] pc = '0;
    logic [CNT_W-1:0] max_cycles = '0;
    logic core_rst_n, core_en, done, timeout, halted;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_cnt;
    int total = 0, bad = 0;
    bit chk_on = 0;
    int pc_mode = 0, k_chg = 4;
    run_state_e m_st = S_IDLE;
    int m_hold = 0;
    logic [PC_W-1:0] hist[$];
    bit m_done = 0, m_to = 0, m_ha = 0, hl, tm;

    risc_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .HALT_WIN(HALT_WIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step), .pc(pc),
        .max_cycles(max_cycles), .core_rst_n(core_rst_n), .core_en(core_en), .state(state),
        .cycle_cnt(cycle_cnt), .done(done), .timeout(timeout), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: enabled cycles are a history of sampled pcs; count, halt and timeout follow from it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = S_IDLE; m_hold = 0; hist.delete(); m_done = 0; m_to = 0; m_ha = 0;
        end else begin
            case (m_st)
                S_IDLE, S_DONE: if (start) begin
                    m_st = S_HOLD; m_hold = RST_HOLD; hist.delete(); m_done = 0; m_to = 0; m_ha = 0;
                end
                S_HOLD: begin
                    m_hold--;
                    if (m_hold == 0) m_st = S_RUN;
                end
                S_RUN: begin
                    hist.push_back(pc);
                    tm = max_cycles != 0 && longint'(hist.size()) == longint'(max_cycles);
                    hl = hist.size() >= HALT_WIN;
                    for (int i = 1; i < HALT_WIN; i++) if (hl && hist[hist.size() - 1 - i] != pc) hl = 0;
                    if (tm || hl) begin
                        m_st = S_DONE; m_done = 1; m_to = tm; m_ha = hl;
                    end
`ifdef RUN_CTRL_STEP_EN
                    else if (step_mode) m_st = S_STEP_WAIT;
`endif
                end
                S_STEP_WAIT: if (!step_mode || step) m_st = S_RUN;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        case (pc_mode)
            0: pc = PC_W'(hist.size() + 3);
            1: pc = (hist.size() < k_chg) ? PC_W'(hist.size()) : 16'h0040;
            default: pc = PC_W'($urandom_range(0, 3));
        endcase
    end

    always @(negedge clk) if (chk_on) begin
        chk("state", state, m_st);
        chk("core_en", core_en, m_st == S_RUN);
        chk("core_rst_n", core_rst_n, !(m_st == S_IDLE || m_st == S_HOLD));
        chk("cycle_cnt", cycle_cnt, hist.size());
        chk("done", done, m_done);
        chk("timeout", timeout, m_to);
        chk("halted", halted, m_ha);
    end

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int lim, output int ens);
        int n = 0;
        ens = 0;
        while (!done && n < lim) begin
            if (core_en) ens++;
            @(negedge clk);
            n++;
        end
        chk("wait_done", done, 1);
    endtask

    initial begin
        int n, ens;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_flags", {done, timeout, halted}, 0);
        chk_on = 1;
        // free run: four held-reset cycles then continuous enable
        pc_mode = 0; max_cycles = 0;
        pulse_start();
        n = 0;
        while (!core_rst_n && n < 20) begin n++; @(negedge clk); end
        chk("hold_len", n, 4);
        ens = 0;
        for (int i = 0; i < 30; i++) begin if (core_en) ens++; @(negedge clk); end
        chk("free_en", ens, 30);
        chk("free_done", done, 0);
        do_reset();
        // cycle limit
        max_cycles = 10;
        pulse_start();
        wait_done(100, ens);
        chk("lim_en", ens, 10);
        chk("lim_cnt", cycle_cnt, 10);
        chk("lim_timeout", timeout, 1);
        chk("lim_halted", halted, 0);
        // halt on constant pc from run cycle 5
        max_cycles = 0; pc_mode = 1; k_chg = 4;
        pulse_start();
        wait_done(100, ens);
        chk("halt_cnt", cycle_cnt, 12);
        chk("halt_flag", halted, 1);
        chk("halt_timeout", timeout, 0);
        chk("halt_model_cnt", hist.size(), 12);
        // halt and timeout together
        max_cycles = 12;
        pulse_start();
        wait_done(100, ens);
        chk("both_cnt", cycle_cnt, 12);
        chk("both_flags", {timeout, halted}, 3);
        // single step: three step pulses four cycles apart
        max_cycles = 0; pc_mode = 0; step_mode = 1;
        pulse_start();
        ens = 0;
        for (int i = 0; i < 40; i++) begin
            step = (i == 10 || i == 14 || i == 18);
            if (core_en) ens++;
            @(negedge clk);
        end
        step = 0;
        chk("step_en", ens, STEP_EN_CNT);
        chk("step_cnt", cycle_cnt, STEP_EN_CNT);
        step_mode = 0;
        do_reset();
        // asynchronous reset mid-run
        pulse_start();
        n = 0;
        while (cycle_cnt != 5 && n < 50) begin n++; @(negedge clk); end
        chk("wait_cnt5", cycle_cnt, 5);
        #2 rst_n = 0;
        #1;
        chk("arst_cnt", cycle_cnt, 0);
        chk("arst_core", {core_rst_n, core_en}, 0);
        chk("arst_flags", {done, timeout, halted}, 0);
        chk("arst_state", state, 0);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("post_rst_state", state, 0);
        // randomized runs
        for (int it = 0; it < 40; it++) begin
            max_cycles = ($urandom_range(0, 2) == 0) ? 0 : CNT_W'($urandom_range(1, 30));
            pc_mode = $urandom_range(0, 2);
            k_chg = $urandom_range(0, 10);
            step_mode = 1'($urandom_range(0, 1));
            pulse_start();
            for (int c = 0; c < 60; c++) begin
                start = ($urandom_range(0, 15) == 0);
                step = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 20) == 0) step_mode = ~step_mode;
                if (c == 30 && $urandom_range(0, 3) == 0) begin
                    #1 rst_n = 0;
                    #2 rst_n = 1;
                end
                @(negedge clk);
            end
            start = 0; step = 0;
            if ($urandom_range(0, 2) == 0) do_reset();
        end
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
